mac_operand_sequencer: RTL and testbench

Upstream feeder for mac_unit. Buffers operand pairs in a small FIFO and issues them one at a time as single-cycle start pulses, with a/b held stable. It then waits for done, captures result, and presents it on a valid/ready output stream. This turns the MAC's start/done protocol into streaming handshakes for the surrounding datapath.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_operand_fifo.sv | 63 ++++++
 rtl/mac_operand_sequencer.sv | 146 ++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types for the MAC operand sequencer: default widths, FSM state
// encoding and the operand pair carried through the operand FIFO.
package mac_pkg;

    localparam int MAC_DATA_WIDTH = 8;
    localparam int MAC_ACC_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } mac_seq_state_t;

    // Field widths are fixed here, so the top's DATA_WIDTH must match MAC_DATA_WIDTH.
    typedef struct packed {
        logic [MAC_DATA_WIDTH-1:0] a;
        logic [MAC_DATA_WIDTH-1:0] b;
    } mac_operand_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous operand-pair FIFO. The head entry is readable combinationally,
// so an entry pushed in one cycle is visible at o_head the next cycle.
module mac_operand_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  mac_operand_t             i_din,
    input  logic                     i_pop,
    output mac_operand_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    mac_operand_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/mac_operand_sequencer.sv
// Streams operand pairs into a start/done MAC and streams its results back out.
// Optional watchdog in WAIT is built when MAC_SEQ_TIMEOUT_EN is defined.
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH     = MAC_DATA_WIDTH,
    parameter int ACC_WIDTH      = MAC_ACC_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_start,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    input  logic                  mac_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  busy,
    output logic                  err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    mac_seq_state_t        r_state;
    logic [DATA_WIDTH-1:0] r_mac_a;
    logic [DATA_WIDTH-1:0] r_mac_b;
    logic                  r_mac_start;
    logic                  r_out_valid;
    logic [ACC_WIDTH-1:0]  r_out_data;

    mac_operand_t          w_din;
    mac_operand_t          w_head;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // in_ready looks only at the registered fill level: a pop in the same
    // cycle never opens a slot for a push at full.
    assign in_ready = ~rst & ~w_full;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_state == IDLE) & ~w_empty;
    assign w_din    = {in_a, in_b};

    mac_operand_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_wait_cnt;
    logic            r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_mac_a     <= w_head.a;
                        r_mac_b     <= w_head.b;
                        r_mac_start <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mac_start <= 1'b0;
                    r_state     <= WAIT;
`ifdef MAC_SEQ_TIMEOUT_EN
                    r_wait_cnt  <= '0;
`endif
                end
                WAIT: begin
                    if (mac_done) begin
                        r_out_data  <= mac_result;
                        r_out_valid <= 1'b1;
                        r_state     <= OUTPUT;
`ifdef MAC_SEQ_TIMEOUT_EN
                    end else if (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Operation abandoned: no result is produced for it.
                        r_err       <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 1'b1;
`endif
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mac_a     = r_mac_a;
    assign mac_b     = r_mac_b;
    assign mac_start = r_mac_start;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != IDLE) | ~w_empty;

`ifdef MAC_SEQ_TIMEOUT_EN
    assign err = r_err;
`else
    // Without the watchdog err is constant 0; the comparison just keeps the
    // timeout parameter referenced in this build.
    assign err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomised bench for mac_operand_sequencer with a behavioural MAC model and
// an in-order result scoreboard. Timeout scenario runs when MAC_SEQ_TIMEOUT_EN is defined.
module tb_mac_operand_sequencer;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_start;
    logic [AW-1:0] mac_result;
    logic          mac_done;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_operand_sequencer #(
        .DATA_WIDTH     (DW),
        .ACC_WIDTH      (AW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_start  (mac_start),
        .mac_result (mac_result),
        .mac_done   (mac_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .err        (err)
    );

    // Behavioural MAC: done pulses model_delay cycles after the start cycle.
    int            cyc = 0;
    int            model_delay = 3;
    bit            model_en = 1'b1;
    logic          inj_done = 1'b0;
    logic          md = 1'b0;
    logic [AW-1:0] mres = '0;
    bit            pv = 1'b0;
    int            pat = 0;
    logic [AW-1:0] pres = '0;
    logic [AW-1:0] prod;

    assign prod       = AW'(mac_a) * AW'(mac_b);
    assign mac_done   = md | inj_done;
    assign mac_result = mres;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_start && model_en) begin
            if (model_delay <= 1) begin
                md   <= 1'b1;
                mres <= prod;
                pv   <= 1'b0;
            end else begin
                md   <= 1'b0;
                pv   <= 1'b1;
                pat  <= cyc + model_delay;
                pres <= prod;
            end
        end else if (pv && (cyc + 1 == pat)) begin
            md   <= 1'b1;
            mres <= pres;
            pv   <= 1'b0;
        end else begin
            md <= 1'b0;
        end
    end

    // Monitors: accepted pushes, result handshakes, issued pulses, stability.
    logic [AW-1:0] got_q[$];
    logic [AW-1:0] exp_q[$];
    int            acc_cnt = 0;
    int            st_cnt = 0;
    int            start_total = 0;
    int            ready_viol = 0;
    int            stab_viol = 0;
    int            start_viol = 0;
    bit            full_seen = 1'b0;
    bit            tracking = 1'b0;
    logic          prev_start = 1'b0;
    logic          prev_err = 1'b0;
    logic [DW-1:0] cap_a = '0;
    logic [DW-1:0] cap_b = '0;

    always @(posedge clk) begin
        if (rst) begin
            acc_cnt <= 0;
        end else begin
            if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                $display("[%0t] result out_data=%0d", $time, out_data);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst) begin
            st_cnt     <= 0;
            tracking   <= 1'b0;
            prev_start <= 1'b0;
        end else begin
            if (in_ready !== ((acc_cnt - st_cnt - int'(mac_start)) < DEPTH))
                ready_viol <= ready_viol + 1;
            if (!in_ready) full_seen <= 1'b1;
            if (mac_start && prev_start) start_viol <= start_viol + 1;
            prev_start <= mac_start;
            if (mac_start) begin
                st_cnt      <= st_cnt + 1;
                start_total <= start_total + 1;
                cap_a       <= mac_a;
                cap_b       <= mac_b;
                tracking    <= 1'b1;
            end else if (tracking) begin
                if (mac_a !== cap_a || mac_b !== cap_b) stab_viol <= stab_viol + 1;
                if (out_valid || (err && !prev_err)) tracking <= 1'b0;
            end
        end
        prev_err <= err;
    end

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL push_timeout a=%0d b=%0d in_ready=%0b required=1", a, b, in_ready);
        end else begin
            exp_q.push_back(AW'(a) * AW'(b));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget, input string tag);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL %s_result_count got=%0d required=%0d", tag, got_q.size(), n);
        end
    endtask

    task automatic wait_start(input int budget, input string tag);
        int c = 0;
        while (!mac_start && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!mac_start) begin
            errors++;
            $display("FAIL %s_start_timeout mac_start=%0b required=1", tag, mac_start);
        end
    endtask

    task automatic compare_results(input string tag);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d required=%0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_data[%0d] got=%0d required=%0d", tag, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_during_rst got=%0b required=0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, mac_start, busy, err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags {in_ready,out_valid,mac_start,busy,err} got=%b required=10000",
                     {in_ready, out_valid, mac_start, busy, err});
        end
        checks++;
        if (mac_a !== '0 || mac_b !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_data mac_a=%0d mac_b=%0d out_data=%0d required=0", mac_a, mac_b, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int s0;
        clear_sb();
        model_delay = 3;
        out_ready = 1'b1;
        s0 = start_total;
        push_pair(8'd3, 8'd4);
        wait_results(1, 100, "single");
        @(negedge clk);
        compare_results("single");
        checks++;
        if (start_total - s0 != 1) begin
            errors++;
            $display("FAIL single_start_count got=%0d required=1", start_total - s0);
        end
        checks++;
        if (got_q.size() > 0 && got_q[0] !== 16'd12) begin
            errors++;
            $display("FAIL single_value got=%0d required=12", got_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        model_delay = 10;
        out_ready = 1'b1;
        full_seen = 1'b0;
        push_pair(8'd3, 8'd4);
        push_pair(8'd5, 8'd6);
        push_pair(8'd7, 8'd8);
        push_pair(8'd2, 8'd9);
        push_pair(8'd1, 8'd1);
        push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        wait_results(6, 500, "b2b");
        compare_results("b2b");
        checks++;
        if (!full_seen) begin
            errors++;
            $display("FAIL b2b_full_seen got=0 required=1");
        end
    endtask

    task automatic test_stall();
        int c = 0;
        clear_sb();
        model_delay = 3;
        out_ready = 1'b0;
        push_pair(8'd5, 8'd6);
        push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        while (!out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd30 || mac_start !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] out_valid=%0b out_data=%0d mac_start=%0b required 1/30/0",
                         i, out_valid, out_data, mac_start);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mac_start !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_after_hs mac_start=%0b out_valid=%0b required 0/0", mac_start, out_valid);
        end
        @(negedge clk);
        checks++;
        if (mac_start !== 1'b1) begin
            errors++;
            $display("FAIL stall_next_issue mac_start=%0b required=1", mac_start);
        end
        wait_results(2, 100, "stall");
        compare_results("stall");
    endtask

    task automatic test_spurious_done();
        int seen = 0;
        clear_sb();
        out_ready = 1'b1;
        model_delay = 6;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_done out_valid_cycles=%0d busy=%0b required 0/0", seen, busy);
        end
        push_pair(8'd7, 8'd3);
        wait_start(50, "spurious");
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL issue_done out_valid=%0b required=0", out_valid);
        end
        wait_results(1, 100, "spurious");
        compare_results("spurious");
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        clear_sb();
        model_delay = 10;
        out_ready = 1'b1;
        push_pair(8'd7, 8'd8);
        push_pair(8'd9, 8'd9);
        wait_start(50, "rstmid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_in_ready got=%0b required=0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, mac_start, busy} !== 3'b000 || mac_a !== '0 || mac_b !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL rstmid_state out_valid=%0b mac_start=%0b busy=%0b mac_a=%0d mac_b=%0d out_data=%0d required all 0",
                     out_valid, mac_start, busy, mac_a, mac_b, out_data);
        end
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid || mac_start || busy) seen++;
        end
        checks++;
        if (seen != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_after_done active_cycles=%0d results=%0d required 0/0", seen, got_q.size());
        end
        clear_sb();
    endtask

    task automatic test_random();
        clear_sb();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                int c = 0;
                while (got_q.size() < 20 && c < 3000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    model_delay = $urandom_range(1, 8);
                    @(negedge clk);
                    c++;
                end
            end
        join
        out_ready = 1'b1;
        compare_results("random");
        checks++;
        if (stab_viol != 0 || start_viol != 0 || ready_viol != 0) begin
            errors++;
            $display("FAIL protocol stab_viol=%0d start_viol=%0d ready_viol=%0d required 0/0/0",
                     stab_viol, start_viol, ready_viol);
        end
    endtask

`ifdef MAC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int seen = 0;
        clear_sb();
        out_ready = 1'b1;
        model_en = 1'b0;
        push_pair(8'd4, 8'd4);
        wait_start(50, "timeout");
        for (int i = 1; i <= TO + 1; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
            if (i == TO) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early err=%0b at wait cycle %0d required=0", err, i);
                end
            end
        end
        checks++;
        if (err !== 1'b1 || seen != 0) begin
            errors++;
            $display("FAIL timeout_err err=%0b out_valid_cycles=%0d required 1/0", err, seen);
        end
        clear_sb();
        model_en = 1'b1;
        model_delay = 3;
        push_pair(8'd2, 8'd3);
        wait_results(1, 100, "timeout");
        compare_results("timeout");
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky err=%0b required=1", err);
        end
    endtask
`else
    task automatic test_err_tied();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied err=%0b required=0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_spurious_done();
        test_reset_mid();
        test_random();
`ifdef MAC_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout sim_time=%0t required finish earlier", $time);
        $fatal(1, "global timeout");
    end

endmodule
